// File: rtl/processing_hw_mul_pkg.sv
// processing_hw_mul_pkg
//   Shared types and elaboration-time parameter checks for the
//   processing_hw_mul_pipe multiplier.
//   - mul_tag_t : per-transaction control tag carried alongside the data
//   - *_ok()    : constant functions used by the top to reject illegal sizes
package processing_hw_mul_pkg;

  typedef struct packed {
    logic valid;
    logic a_signed;
    logic b_signed;
    logic acc_en;
    logic acc_clr;
  } mul_tag_t;

  // Both operands need at least one magnitude bit next to the sign bit.
  function automatic bit widths_ok(input int a_w, input int b_w);
    return (a_w >= 32'sd2) && (b_w >= 32'sd2);
  endfunction

  // Stage 1 (operand register) and stage 2 (product register) are mandatory.
  function automatic bit stages_ok(input int num_stage);
    return num_stage >= 32'sd2;
  endfunction

  // The accumulator must hold any single product without truncation.
  function automatic bit acc_ok(input int acc_w, input int a_w, input int b_w);
    return acc_w >= (a_w + b_w);
  endfunction

endpackage

// File: rtl/processing_hw_mul_core.sv
// processing_hw_mul_core
//   Stages 1-2 of the multiplier: operand/tag register with 1-bit sign or
//   zero extension, then the product register. Kept apart so the multiply
//   maps onto a DSP block on its own.
// Ports:
//   clk, reset (async, active-low), ce (stall: low holds every register)
//   in_valid, a, b, a_signed, b_signed, acc_en, acc_clr : transaction inputs
//   tag_o, p_o, p_signed_o       : stage-2 register contents
//   tag_d_o, p_d_o, p_signed_d_o : values entering stage 2 on the next edge
module processing_hw_mul_core
  import processing_hw_mul_pkg::*;
#(
  parameter int A_WIDTH = 11,
  parameter int B_WIDTH = 12,
  localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               a_signed,
  input  logic               b_signed,
  input  logic               acc_en,
  input  logic               acc_clr,
  output mul_tag_t           tag_o,
  output logic [P_WIDTH-1:0] p_o,
  output logic               p_signed_o,
  output mul_tag_t           tag_d_o,
  output logic [P_WIDTH-1:0] p_d_o,
  output logic               p_signed_d_o
);

  logic [A_WIDTH:0]   a_ext_q, a_ext_d;
  logic [B_WIDTH:0]   b_ext_q, b_ext_d;
  mul_tag_t           tag1_q, tag1_d;
  mul_tag_t           tag2_q, tag2_d;
  logic [P_WIDTH-1:0] p_q, p_d;
  logic               psig_q, psig_d;
  logic [P_WIDTH-1:0] a_wide_s, b_wide_s, prod_s;

  // Stage 1 next state: extend each operand by one bit according to its mode.
  always_comb begin
    a_ext_d = a_ext_q;
    b_ext_d = b_ext_q;
    tag1_d  = tag1_q;
    if (ce) begin
      if (a_signed) begin
        a_ext_d = {a[A_WIDTH-1], a};
      end else begin
        a_ext_d = {1'b0, a};
      end
      if (b_signed) begin
        b_ext_d = {b[B_WIDTH-1], b};
      end else begin
        b_ext_d = {1'b0, b};
      end
      tag1_d = '{valid: in_valid, a_signed: a_signed, b_signed: b_signed,
                 acc_en: acc_en, acc_clr: acc_clr};
    end else begin
      a_ext_d = a_ext_q;
      b_ext_d = b_ext_q;
      tag1_d  = tag1_q;
    end
  end

  // Both extended operands are now signed; widening them to P_WIDTH and
  // multiplying modulo 2^P_WIDTH yields the exact signed product, since
  // every mode combination fits in P_WIDTH bits.
  assign a_wide_s = {{(B_WIDTH-1){a_ext_q[A_WIDTH]}}, a_ext_q};
  assign b_wide_s = {{(A_WIDTH-1){b_ext_q[B_WIDTH]}}, b_ext_q};
  assign prod_s   = a_wide_s * b_wide_s;

  // Stage 2 next state: tag always advances, product only on valid so that
  // p keeps its last valid value through bubbles.
  always_comb begin
    tag2_d = tag2_q;
    p_d    = p_q;
    psig_d = psig_q;
    if (ce) begin
      tag2_d = tag1_q;
    end else begin
      tag2_d = tag2_q;
    end
    if (ce && tag1_q.valid) begin
      p_d    = prod_s;
      psig_d = tag1_q.a_signed | tag1_q.b_signed;
    end else begin
      p_d    = p_q;
      psig_d = psig_q;
    end
  end

  // Stage 1 and stage 2 registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_ext_q <= '0;
      b_ext_q <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      p_q     <= '0;
      psig_q  <= 1'b0;
    end else begin
      a_ext_q <= a_ext_d;
      b_ext_q <= b_ext_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      p_q     <= p_d;
      psig_q  <= psig_d;
    end
  end

  assign tag_o        = tag2_q;
  assign p_o          = p_q;
  assign p_signed_o   = psig_q;
  assign tag_d_o      = tag2_d;
  assign p_d_o        = p_d;
  assign p_signed_d_o = psig_d;

endmodule

// File: rtl/processing_hw_mul_pipe.sv
// processing_hw_mul_pipe
//   Pipelined multiplier with valid-tagged stages, per-transaction operand
//   signedness and a signed multiply-accumulate register with sticky
//   overflow. Latency is NUM_STAGE enabled cycles; ce low stalls everything.
// Ports:
//   clk, reset (async, active-low), ce
//   in_valid, a, b, a_signed, b_signed, acc_en, acc_clr : transaction inputs
//   out_valid, p, p_signed : product output (p held through bubbles)
//   acc, acc_ovf           : accumulator and its sticky overflow flag
module processing_hw_mul_pipe
  import processing_hw_mul_pkg::*;
#(
  parameter int A_WIDTH   = 11,
  parameter int B_WIDTH   = 12,
  parameter int NUM_STAGE = 4,
  parameter int ACC_WIDTH = 31,
  localparam int P_WIDTH  = A_WIDTH + B_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic                 out_valid,
  output logic [P_WIDTH-1:0]   p,
  output logic                 p_signed,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_ovf
);

  localparam int DLY = NUM_STAGE - 2;

  if (!(widths_ok(A_WIDTH, B_WIDTH) && stages_ok(NUM_STAGE) &&
        acc_ok(ACC_WIDTH, A_WIDTH, B_WIDTH))) begin : g_bad_params
    $error("processing_hw_mul_pipe: illegal parameter combination");
  end

  mul_tag_t           core_tag_s, core_tag_d_s;
  logic [P_WIDTH-1:0] core_p_s, core_p_d_s;
  logic               core_psig_s, core_psig_d_s;

  // ent_*: what enters the output stage on the next edge; out_*: its contents.
  mul_tag_t           ent_tag_s, out_tag_s;
  logic [P_WIDTH-1:0] ent_p_s, out_p_s;
  logic               ent_psig_s, out_psig_s;

  processing_hw_mul_core #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .in_valid     (in_valid),
    .a            (a),
    .b            (b),
    .a_signed     (a_signed),
    .b_signed     (b_signed),
    .acc_en       (acc_en),
    .acc_clr      (acc_clr),
    .tag_o        (core_tag_s),
    .p_o          (core_p_s),
    .p_signed_o   (core_psig_s),
    .tag_d_o      (core_tag_d_s),
    .p_d_o        (core_p_d_s),
    .p_signed_d_o (core_psig_d_s)
  );

  if (DLY == 0) begin : g_direct
    assign ent_tag_s  = core_tag_d_s;
    assign ent_p_s    = core_p_d_s;
    assign ent_psig_s = core_psig_d_s;
    assign out_tag_s  = core_tag_s;
    assign out_p_s    = core_p_s;
    assign out_psig_s = core_psig_s;
  end else begin : g_delay
    mul_tag_t           tag_q  [DLY];
    mul_tag_t           tag_d  [DLY];
    logic [P_WIDTH-1:0] p_q    [DLY];
    logic [P_WIDTH-1:0] p_d    [DLY];
    logic               psig_q [DLY];
    logic               psig_d [DLY];
    logic               unused_core_d_s;

    assign unused_core_d_s = ^{core_tag_d_s, core_p_d_s, core_psig_d_s};

    // Delay-line next state: tags shift every enabled edge, data only
    // follows a valid tag so bubbles leave the last product in place.
    always_comb begin
      if (ce) begin
        tag_d[0] = core_tag_s;
      end else begin
        tag_d[0] = tag_q[0];
      end
      if (ce && core_tag_s.valid) begin
        p_d[0]    = core_p_s;
        psig_d[0] = core_psig_s;
      end else begin
        p_d[0]    = p_q[0];
        psig_d[0] = psig_q[0];
      end
      for (int i = 1; i < DLY; i++) begin
        if (ce) begin
          tag_d[i] = tag_q[i-1];
        end else begin
          tag_d[i] = tag_q[i];
        end
        if (ce && tag_q[i-1].valid) begin
          p_d[i]    = p_q[i-1];
          psig_d[i] = psig_q[i-1];
        end else begin
          p_d[i]    = p_q[i];
          psig_d[i] = psig_q[i];
        end
      end
    end

    // Delay-line registers (stages 3..NUM_STAGE).
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < DLY; i++) begin
          tag_q[i]  <= '0;
          p_q[i]    <= '0;
          psig_q[i] <= 1'b0;
        end
      end else begin
        for (int i = 0; i < DLY; i++) begin
          tag_q[i]  <= tag_d[i];
          p_q[i]    <= p_d[i];
          psig_q[i] <= psig_d[i];
        end
      end
    end

    assign ent_tag_s  = tag_d[DLY-1];
    assign ent_p_s    = p_d[DLY-1];
    assign ent_psig_s = psig_d[DLY-1];
    assign out_tag_s  = tag_q[DLY-1];
    assign out_p_s    = p_q[DLY-1];
    assign out_psig_s = psig_q[DLY-1];
  end

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 acc_ovf_q, acc_ovf_d;
  logic [ACC_WIDTH-1:0] ext_p_s, sum_s;
  logic                 add_ovf_s;
  logic                 unused_tag_s;

  // Only valid/acc_en/acc_clr steer the accumulator; the signedness bits
  // already travel with the data as p_signed.
  assign unused_tag_s = ^{out_tag_s.a_signed, out_tag_s.b_signed, out_tag_s.acc_en,
                          out_tag_s.acc_clr, ent_tag_s.a_signed, ent_tag_s.b_signed};

  // Product extension to accumulator width and the two's complement add.
  always_comb begin
    if (ent_psig_s) begin
      ext_p_s = ACC_WIDTH'($signed(ent_p_s));
    end else begin
      ext_p_s = ACC_WIDTH'(ent_p_s);
    end
    sum_s     = acc_q + ext_p_s;
    // Overflow: operands agree in sign but the result does not.
    add_ovf_s = (acc_q[ACC_WIDTH-1] == ext_p_s[ACC_WIDTH-1]) &&
                (sum_s[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  end

  // Accumulator next state, taken on the edge a valid product lands in the
  // output stage. A clear always wins over any overflow.
  always_comb begin
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    if (ce && ent_tag_s.valid) begin
      case ({ent_tag_s.acc_clr, ent_tag_s.acc_en})
        2'b11: begin
          acc_d     = ext_p_s;
          acc_ovf_d = 1'b0;
        end
        2'b10: begin
          acc_d     = '0;
          acc_ovf_d = 1'b0;
        end
        2'b01: begin
          acc_d     = sum_s;
          acc_ovf_d = acc_ovf_q | add_ovf_s;
        end
        default: begin
          acc_d     = acc_q;
          acc_ovf_d = acc_ovf_q;
        end
      endcase
    end else begin
      acc_d     = acc_q;
      acc_ovf_d = acc_ovf_q;
    end
  end

  // Accumulator and overflow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
    end
  end

  assign out_valid = out_tag_s.valid;
  assign p         = out_p_s;
  assign p_signed  = out_psig_s;
  assign acc       = acc_q;
  assign acc_ovf   = acc_ovf_q;

endmodule

// File: doc/processing_hw_mul_pipe.md
# processing_hw_mul_pipe

Parametrised, pipelined integer multiplier with a valid-tagged pipeline, per-transaction operand signedness and an optional multiply-accumulate stage. It is the general multiplier used by the Processing_HW datapath. It replaces fixed-width, fixed-latency, unsigned-only multiplier instances. It keeps the same clock-enable stall semantics, so HLS-style schedulers can drive it unchanged.

## Interface
- A_WIDTH, 11, operand a width (≥2)
- B_WIDTH, 12, operand b width (≥2)
- NUM_STAGE, 4, total latency in enabled cycles (≥2)
- ACC_WIDTH, 31, accumulator width (≥ A_WIDTH+B_WIDTH)
- P_WIDTH (localparam), A_WIDTH+B_WIDTH, product width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; low freezes every register, including valid tags
- in_valid  in  1  operands present this cycle
- a  in  A_WIDTH  operand a
- b  in  B_WIDTH  operand b
- a_signed  in  1  treat a as two's complement
- b_signed  in  1  treat b as two's complement
- acc_en  in  1  add this product into the accumulator
- acc_clr  in  1  restart the accumulator with this transaction
- out_valid  out  1  p holds a new result
- p  out  P_WIDTH  product
- p_signed  out  1  p is signed (a_signed|b_signed of that transaction)
- acc  out  ACC_WIDTH  signed accumulator
- acc_ovf  out  1  sticky signed-overflow flag of acc

## Operation
- Each transaction carries a tag {valid, a_signed, b_signed, acc_en, acc_clr} down a shift register alongside the data.
- Stage 1 registers a, b and the tag. Each operand is extended by 1 bit: sign-extended if its signed flag is set, zero-extended otherwise.
- Stage 2 forms the signed product of the extended operands, truncated to P_WIDTH. No information is lost for any mode combination.
- Stages 3..NUM_STAGE are pure delay. If NUM_STAGE=2, stage 2 drives the outputs directly.
- A bubble (in_valid=0) propagates as valid=0. The p data value during a bubble is don't-care, but p is held at its last valid value.
- Accumulator update, on the edge where a valid tagged product enters the output stage:
  - acc_clr=1, acc_en=1: acc ← ext(p)
  - acc_clr=1, acc_en=0: acc ← 0
  - acc_clr=0, acc_en=1: acc ← acc + ext(p)
  - otherwise: acc holds
- ext(p) sign-extends p to ACC_WIDTH when p_signed=1 and zero-extends it otherwise.
- acc_ovf:
  - set when the add's true result is outside the signed ACC_WIDTH range; acc wraps modulo 2^ACC_WIDTH
  - stays set until a valid acc_clr transaction reaches the output stage
  - on that transaction it becomes the overflow of the load, which is always 0

## Timing
- Latency: the result of operands sampled on enabled edge k appears on out_valid/p after enabled edge k+NUM_STAGE-1. Counted in ce-high cycles only.
- Throughput: one transaction per ce-high cycle. There is no backpressure; the consumer must use ce to stall.
- ce=0: all pipeline, tag, acc and acc_ovf registers hold, and outputs are frozen. Inputs in that cycle are ignored.
- acc and acc_ovf update on the same edge that raises out_valid for the corresponding transaction.
- Reset (asynchronous assert, released synchronously by the system): every register clears to 0, so out_valid=0, p=0, p_signed=0, acc=0, acc_ovf=0.
- Reset mid-operation discards all in-flight transactions. The first out_valid after release comes NUM_STAGE-1 enabled edges after the first valid input.
- Simultaneous acc_clr and overflow in the same transaction: the clear wins and acc_ovf=0.

## Structure
- Package processing_hw_mul_pkg holds:
  - the tag struct type mul_tag_t {valid, a_signed, b_signed, acc_en, acc_clr}
  - parameter legality checks as constant functions
- Sub-module processing_hw_mul_core contains stages 1–2 (extension plus product register), so a DSP-inferrable multiply sits in isolation.
- The top level contains the delay line, the tag pipeline and the accumulator.

## Test plan
- Unsigned maximum: a=2047, b=4095, both signed flags 0, one valid → out_valid after 3 enabled edges (NUM_STAGE=4), p=8382465, p_signed=0.
- Signed: a=0x7FF, b=0xFFF, both signed flags 1 → p=1. Mixed: a=0x7FF with a_signed=1, b=4095 with b_signed=0 → p=0x7FF001 (−4095), p_signed=1.
- Accumulate: three back-to-back a=2047, b=4095 transactions, the first with acc_clr=1 and all with acc_en=1 → acc=8382465, 16764930, 25147395 on consecutive edges.
- Stall: drop ce for 5 cycles while 3 transactions are in flight → outputs frozen for those cycles, order preserved, and no duplicate or lost out_valid.
- Overflow (ACC_WIDTH=24): two 2047×4095 accumulations → acc_ovf=1 after the second and stays 1 through bubbles. The next acc_clr transaction clears it.
- Assert reset with 3 transactions in flight → all outputs 0 immediately. After release, no stale out_valid appears.
